// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the time-division multiplexed CPU bus.
// Struct fields are sized for the largest supported configuration; users take the low bits.
package cpu_bus_pkg;

    localparam int SLOT_PHASE_SETUP = 0;
    localparam int MAX_CPU          = 4;
    localparam int MAX_DATA_W       = 32;
    localparam int MAX_SEL          = 8;

    typedef logic [$clog2(MAX_CPU)-1:0] owner_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_SLOT = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [15:0]           addr;
        logic [MAX_DATA_W-1:0] data;
        logic                  rnw;
        logic                  req;
        logic [MAX_SEL-1:0]    cs_n;
    } slot_latch_t;

    function automatic int owner_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic owner_t wrap_inc(input owner_t cur, input int n);
        return owner_t'((int'(cur) + 1) % n);
    endfunction

endpackage

// File: rtl/slot_sequencer.sv
// Slot phase counter and owner arbitration (fixed round-robin or skip-idle).
//   state    | meaning
//   SEQ_IDLE | no slot in progress (after reset, or skip-idle with no requester)
//   SEQ_SLOT | a slot is running, phase counts 0..SLOT_CYCLES-1
module slot_sequencer
    import cpu_bus_pkg::*;
#(
    parameter int NUM_CPU     = 2,
    parameter int SLOT_CYCLES = 2,
    parameter int SKIP_IDLE   = 0
) (
    input  logic                            clk_sys,
    input  logic                            rst_b,
    input  logic [NUM_CPU-1:0]              req,
    output logic [owner_width(NUM_CPU)-1:0] owner,
    output logic                            slot_start,
    output logic                            slot_last,
    output logic                            start_nxt,
    output logic                            idle_nxt,
    output logic [owner_width(NUM_CPU)-1:0] owner_nxt
);
    localparam int OW = owner_width(NUM_CPU);
    localparam int PW = $clog2(SLOT_CYCLES);
    localparam logic [PW-1:0] LAST_PHASE  = PW'(SLOT_CYCLES - 1);
    localparam logic [PW-1:0] SETUP_PHASE = PW'(SLOT_PHASE_SETUP);

    seq_state_t    state;
    logic [PW-1:0] phase;
    logic          fresh;

    assign slot_last = (state == SEQ_SLOT) && (phase == LAST_PHASE);

    // Until the first grant there is no previous owner, so the search starts at CPU 0.
    always_comb begin
        int base;
        owner_nxt = owner;
        start_nxt = 1'b0;
        idle_nxt  = 1'b0;
        base      = fresh ? 0 : int'(wrap_inc(owner_t'(owner), NUM_CPU));
        if ((state == SEQ_IDLE) || (phase == LAST_PHASE)) begin
            if (SKIP_IDLE == 0) begin
                start_nxt = 1'b1;
                owner_nxt = OW'(base);
            end else begin
                idle_nxt = 1'b1;
                for (int k = NUM_CPU - 1; k >= 0; k--) begin
                    for (int c = 0; c < NUM_CPU; c++) begin
                        if ((c == (base + k) % NUM_CPU) && req[c]) begin
                            start_nxt = 1'b1;
                            idle_nxt  = 1'b0;
                            owner_nxt = OW'(c);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            state      <= SEQ_IDLE;
            phase      <= SETUP_PHASE;
            owner      <= '0;
            slot_start <= 1'b0;
            fresh      <= 1'b1;
        end else begin
            slot_start <= start_nxt;
            if (start_nxt) begin
                state <= SEQ_SLOT;
                phase <= SETUP_PHASE;
                owner <= owner_nxt;
                fresh <= 1'b0;
            end else if (idle_nxt) begin
                state <= SEQ_IDLE;
                phase <= SETUP_PHASE;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_bus_tdm.sv
// Shares one video/latch bus between NUM_CPU CPUs in fixed-length time slots.
// Holds the per-slot request latch, drives the shared bus and returns read data / acks.
module cpu_bus_tdm
    import cpu_bus_pkg::*;
#(
    parameter int NUM_CPU     = 2,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int NUM_SEL     = 4,
    parameter int SLOT_CYCLES = 2,
    parameter int SKIP_IDLE   = 0
) (
    input  logic                            CLK_6M,
    input  logic                            nRESET,
    input  logic [NUM_CPU*16-1:0]           cpu_a,
    input  logic [NUM_CPU*DATA_W-1:0]       cpu_dout,
    input  logic [NUM_CPU-1:0]              cpu_rnw,
    input  logic [NUM_CPU-1:0]              cpu_req,
    input  logic [NUM_CPU*NUM_SEL-1:0]      cpu_cs_n,
    output logic [ADDR_W-1:0]               A,
    output logic [DATA_W-1:0]               D_out,
    output logic                            D_oe,
    input  logic [DATA_W-1:0]               D_in,
    output logic                            nWE,
    output logic [NUM_SEL-1:0]              sel_n,
    output logic [owner_width(NUM_CPU)-1:0] owner,
    output logic                            slot_start,
    output logic [NUM_CPU*DATA_W-1:0]       cpu_rdata,
    output logic [NUM_CPU-1:0]              cpu_ack
);
    localparam int OW = owner_width(NUM_CPU);

    logic          slot_last;
    logic          start_nxt;
    logic          idle_nxt;
    logic [OW-1:0] owner_nxt;
    slot_latch_t   latch_q;
    slot_latch_t   latch_nxt;
    logic          unused_latch_bits;

    slot_sequencer #(
        .NUM_CPU     (NUM_CPU),
        .SLOT_CYCLES (SLOT_CYCLES),
        .SKIP_IDLE   (SKIP_IDLE)
    ) u_seq (
        .clk_sys    (CLK_6M),
        .rst_b      (nRESET),
        .req        (cpu_req),
        .owner      (owner),
        .slot_start (slot_start),
        .slot_last  (slot_last),
        .start_nxt  (start_nxt),
        .idle_nxt   (idle_nxt),
        .owner_nxt  (owner_nxt)
    );

    // Upper latch bits exist only for wider configurations.
    assign unused_latch_bits = ^latch_q;

    always_comb begin
        latch_nxt = '0;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (int'(owner_nxt) == i) begin
                latch_nxt.addr                = cpu_a[16*i +: 16];
                latch_nxt.data[DATA_W-1:0]    = cpu_dout[DATA_W*i +: DATA_W];
                latch_nxt.rnw                 = cpu_rnw[i];
                latch_nxt.req                 = cpu_req[i];
                latch_nxt.cs_n[NUM_SEL-1:0]   = cpu_cs_n[NUM_SEL*i +: NUM_SEL];
            end
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (!nRESET) begin
            latch_q   <= '0;
            A         <= '0;
            D_out     <= '0;
            D_oe      <= 1'b0;
            nWE       <= 1'b1;
            sel_n     <= '1;
            cpu_rdata <= '0;
            cpu_ack   <= '0;
        end else begin
            cpu_ack <= '0;
            if (slot_last && latch_q.req) begin
                for (int i = 0; i < NUM_CPU; i++) begin
                    if (int'(owner) == i) begin
                        cpu_ack[i] <= 1'b1;
                        if (latch_q.rnw) begin
                            cpu_rdata[DATA_W*i +: DATA_W] <= D_in;
                        end
                    end
                end
            end

            if (start_nxt) begin
                latch_q <= latch_nxt;
                nWE     <= 1'b1;
                if (latch_nxt.req) begin
                    A     <= latch_nxt.addr[ADDR_W-1:0];
                    D_out <= latch_nxt.data[DATA_W-1:0];
                    D_oe  <= ~latch_nxt.rnw;
                    sel_n <= latch_nxt.cs_n[NUM_SEL-1:0];
                end else begin
                    D_oe  <= 1'b0;
                    sel_n <= '1;
                end
            end else if (idle_nxt) begin
                latch_q.req <= 1'b0;
                D_oe        <= 1'b0;
                sel_n       <= '1;
                nWE         <= 1'b1;
            end else begin
                // Phase 0 always keeps nWE high so back-to-back writes are separated.
                nWE <= ~(latch_q.req & ~latch_q.rnw);
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_tdm.sv
// Random-stimulus bench: a fixed round-robin instance (2 CPUs) and a skip-idle instance (4 CPUs)
// compared every cycle against an edge-counting slot model.
module tb_cpu_bus_tdm;
    localparam int SC = 2;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int N0 = 2;
    localparam int N1 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // stimulus, indexed [dut][cpu]
    logic [15:0] st_a   [2][4];
    logic [7:0]  st_d   [2][4];
    logic [3:0]  st_cs  [2][4];
    logic [3:0]  st_req [2];
    logic [3:0]  st_rnw [2];
    logic [7:0]  st_din [2];

    // fixed-mode DUT
    logic [N0*16-1:0] f_cpu_a;
    logic [N0*DW-1:0] f_cpu_dout;
    logic [N0*NS-1:0] f_cpu_cs_n;
    logic [N0-1:0]    f_cpu_rnw, f_cpu_req, f_cpu_ack;
    logic [AW-1:0]    f_A;
    logic [DW-1:0]    f_D_out, f_D_in;
    logic             f_D_oe, f_nWE, f_slot_start;
    logic [NS-1:0]    f_sel_n;
    logic [0:0]       f_owner;
    logic [N0*DW-1:0] f_cpu_rdata;

    // skip-idle DUT
    logic [N1*16-1:0] s_cpu_a;
    logic [N1*DW-1:0] s_cpu_dout;
    logic [N1*NS-1:0] s_cpu_cs_n;
    logic [N1-1:0]    s_cpu_rnw, s_cpu_req, s_cpu_ack;
    logic [AW-1:0]    s_A;
    logic [DW-1:0]    s_D_out, s_D_in;
    logic             s_D_oe, s_nWE, s_slot_start;
    logic [NS-1:0]    s_sel_n;
    logic [1:0]       s_owner;
    logic [N1*DW-1:0] s_cpu_rdata;

    always_comb begin
        f_cpu_a = '0; f_cpu_dout = '0; f_cpu_cs_n = '0;
        s_cpu_a = '0; s_cpu_dout = '0; s_cpu_cs_n = '0;
        for (int i = 0; i < N0; i++) begin
            f_cpu_a[16*i +: 16]   = st_a[0][i];
            f_cpu_dout[DW*i +: DW] = st_d[0][i];
            f_cpu_cs_n[NS*i +: NS] = st_cs[0][i];
        end
        for (int i = 0; i < N1; i++) begin
            s_cpu_a[16*i +: 16]   = st_a[1][i];
            s_cpu_dout[DW*i +: DW] = st_d[1][i];
            s_cpu_cs_n[NS*i +: NS] = st_cs[1][i];
        end
    end
    assign f_cpu_req = st_req[0][N0-1:0];
    assign f_cpu_rnw = st_rnw[0][N0-1:0];
    assign f_D_in    = st_din[0];
    assign s_cpu_req = st_req[1];
    assign s_cpu_rnw = st_rnw[1];
    assign s_D_in    = st_din[1];

    cpu_bus_tdm #(.NUM_CPU(N0), .ADDR_W(AW), .DATA_W(DW), .NUM_SEL(NS),
                  .SLOT_CYCLES(SC), .SKIP_IDLE(0)) u_fixed (
        .CLK_6M(clk), .nRESET(rst_n), .cpu_a(f_cpu_a), .cpu_dout(f_cpu_dout),
        .cpu_rnw(f_cpu_rnw), .cpu_req(f_cpu_req), .cpu_cs_n(f_cpu_cs_n),
        .A(f_A), .D_out(f_D_out), .D_oe(f_D_oe), .D_in(f_D_in), .nWE(f_nWE),
        .sel_n(f_sel_n), .owner(f_owner), .slot_start(f_slot_start),
        .cpu_rdata(f_cpu_rdata), .cpu_ack(f_cpu_ack));

    cpu_bus_tdm #(.NUM_CPU(N1), .ADDR_W(AW), .DATA_W(DW), .NUM_SEL(NS),
                  .SLOT_CYCLES(SC), .SKIP_IDLE(1)) u_skip (
        .CLK_6M(clk), .nRESET(rst_n), .cpu_a(s_cpu_a), .cpu_dout(s_cpu_dout),
        .cpu_rnw(s_cpu_rnw), .cpu_req(s_cpu_req), .cpu_cs_n(s_cpu_cs_n),
        .A(s_A), .D_out(s_D_out), .D_oe(s_D_oe), .D_in(s_D_in), .nWE(s_nWE),
        .sel_n(s_sel_n), .owner(s_owner), .slot_start(s_slot_start),
        .cpu_rdata(s_cpu_rdata), .cpu_ack(s_cpu_ack));

    // reference model state, indexed by dut
    int          m_e     [2];
    bit          m_in    [2];
    int          m_start [2];
    int          m_cur   [2];
    bit          m_fresh [2];
    logic [15:0] sn_a    [2];
    logic [7:0]  sn_d    [2];
    logic [3:0]  sn_cs   [2];
    bit          sn_rnw  [2];
    bit          sn_req  [2];
    int          x_owner [2];
    bit          x_ss    [2];
    logic [15:0] x_A     [2];
    logic [3:0]  x_sel   [2];
    bit          x_doe   [2];
    logic [7:0]  x_dout  [2];
    bit          x_nwe   [2];
    logic [3:0]  x_ack   [2];
    logic [7:0]  x_rd    [2][4];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step(input int m, input int n, input bit skip);
        bit begin_slot;
        bit found;
        int nxt;
        if (!rst_n) begin
            m_e[m] = 0; m_in[m] = 0; m_cur[m] = 0; m_fresh[m] = 1; m_start[m] = 0;
            sn_req[m] = 0;
            x_owner[m] = 0; x_ss[m] = 0; x_A[m] = '0; x_sel[m] = 4'hF; x_doe[m] = 0;
            x_dout[m] = '0; x_nwe[m] = 1; x_ack[m] = '0;
            for (int i = 0; i < 4; i++) x_rd[m][i] = '0;
            return;
        end
        x_ack[m] = '0;
        if (skip) begin_slot = !m_in[m] || (m_e[m] - m_start[m] == SC);
        else      begin_slot = (m_e[m] % SC == 0);
        if (begin_slot) begin
            if (m_in[m] && sn_req[m]) begin
                x_ack[m][m_cur[m]] = 1'b1;
                if (sn_rnw[m]) x_rd[m][m_cur[m]] = st_din[m];
            end
            found = 0;
            nxt   = 0;
            if (skip) begin
                for (int k = 0; k < n && !found; k++) begin
                    nxt = ((m_fresh[m] ? 0 : m_cur[m] + 1) + k) % n;
                    if (st_req[m][nxt]) found = 1;
                end
            end else begin
                found = 1;
                nxt   = (m_e[m] / SC) % n;
            end
            if (found) begin
                m_in[m] = 1; m_start[m] = m_e[m]; m_cur[m] = nxt; m_fresh[m] = 0;
                sn_a[m] = st_a[m][nxt]; sn_d[m] = st_d[m][nxt]; sn_cs[m] = st_cs[m][nxt];
                sn_rnw[m] = st_rnw[m][nxt]; sn_req[m] = st_req[m][nxt];
                x_owner[m] = nxt; x_ss[m] = 1; x_nwe[m] = 1;
                if (sn_req[m]) begin
                    x_A[m] = sn_a[m]; x_sel[m] = sn_cs[m]; x_doe[m] = !sn_rnw[m]; x_dout[m] = sn_d[m];
                end else begin
                    x_sel[m] = 4'hF; x_doe[m] = 0;
                end
            end else begin
                m_in[m] = 0; sn_req[m] = 0;
                x_ss[m] = 0; x_sel[m] = 4'hF; x_doe[m] = 0; x_nwe[m] = 1;
            end
        end else begin
            x_ss[m]  = 0;
            x_nwe[m] = !(sn_req[m] && !sn_rnw[m]);
        end
        m_e[m]++;
    endtask

    task automatic check_dut(input int m, input int n);
        logic [31:0] g_owner, g_ss, g_A, g_sel, g_doe, g_dout, g_nwe, g_ack;
        logic [7:0]  g_rd [4];
        for (int i = 0; i < 4; i++) g_rd[i] = '0;
        if (m == 0) begin
            g_owner = 32'(f_owner); g_ss = 32'(f_slot_start); g_A = 32'(f_A); g_sel = 32'(f_sel_n);
            g_doe = 32'(f_D_oe); g_dout = 32'(f_D_out); g_nwe = 32'(f_nWE); g_ack = 32'(f_cpu_ack);
            for (int i = 0; i < N0; i++) g_rd[i] = f_cpu_rdata[DW*i +: DW];
        end else begin
            g_owner = 32'(s_owner); g_ss = 32'(s_slot_start); g_A = 32'(s_A); g_sel = 32'(s_sel_n);
            g_doe = 32'(s_D_oe); g_dout = 32'(s_D_out); g_nwe = 32'(s_nWE); g_ack = 32'(s_cpu_ack);
            for (int i = 0; i < N1; i++) g_rd[i] = s_cpu_rdata[DW*i +: DW];
        end
        check_val($sformatf("m%0d.owner", m), g_owner, 32'(x_owner[m]));
        check_val($sformatf("m%0d.slot_start", m), g_ss, 32'(x_ss[m]));
        check_val($sformatf("m%0d.A", m), g_A, 32'(x_A[m][AW-1:0]));
        check_val($sformatf("m%0d.sel_n", m), g_sel, 32'(x_sel[m]));
        check_val($sformatf("m%0d.D_oe", m), g_doe, 32'(x_doe[m]));
        if (x_doe[m]) check_val($sformatf("m%0d.D_out", m), g_dout, 32'(x_dout[m]));
        check_val($sformatf("m%0d.nWE", m), g_nwe, 32'(x_nwe[m]));
        check_val($sformatf("m%0d.ack", m), g_ack, 32'(x_ack[m]));
        for (int i = 0; i < n; i++)
            check_val($sformatf("m%0d.rdata%0d", m, i), 32'(g_rd[i]), 32'(x_rd[m][i]));
    endtask

    task automatic run_cycle(input logic [3:0] mask0, input logic [3:0] mask1, input bit rst_val);
        @(negedge clk);
        check_dut(0, N0);
        check_dut(1, N1);
        rst_n = rst_val;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                st_a[m][i]  = 16'($urandom);
                st_d[m][i]  = 8'($urandom);
                st_cs[m][i] = 4'($urandom);
            end
            st_rnw[m] = 4'($urandom);
            st_din[m] = 8'($urandom);
        end
        st_req[0] = 4'($urandom) & mask0;
        st_req[1] = 4'($urandom) & mask1;
        @(posedge clk);
        model_step(0, N0, 1'b0);
        model_step(1, N1, 1'b1);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                st_a[m][i] = '0; st_d[m][i] = '0; st_cs[m][i] = 4'hF;
            end
            st_req[m] = '0; st_rnw[m] = '0; st_din[m] = '0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        model_step(0, N0, 1'b0);
        model_step(1, N1, 1'b1);

        repeat (3)   run_cycle(4'hF, 4'hF, 1'b0);
        repeat (120) run_cycle(4'hF, 4'hF, 1'b1);
        repeat (30)  run_cycle(4'h1, 4'h4, 1'b1);   // CPU1 idle / CPU2 alone
        repeat (30)  run_cycle(4'h2, 4'h6, 1'b1);   // CPU1 and CPU2 contend
        repeat (10)  run_cycle(4'h0, 4'h0, 1'b1);   // whole bus idle
        repeat (300) run_cycle(4'hF, 4'hF, ($urandom_range(0, 49) != 0));
        repeat (4)   run_cycle(4'hF, 4'hF, 1'b1);
        @(negedge clk);
        check_dut(0, N0);
        check_dut(1, N1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
